// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns SRAM-style load/store requests into a
// valid/ready bus transaction, stalls until the response and right-aligns loads.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_read,
  input  logic              lsu_web,
  input  logic [31:0]       lsu_bweb,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rerr,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              access_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT != 0);
  localparam logic [15:0] TimeoutLast = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] load_data_q;

  logic       acc;
  logic       we_in;
  logic [3:0] wstrb_in;
  logic       capture;
  logic       resp;
  logic       tmo;

  // A simultaneous read and write strobe is treated as a store.
  assign acc   = lsu_read | ~lsu_web;
  assign we_in = ~lsu_web;

  always_comb begin
    wstrb_in = '0;
    for (int i = 0; i < 4; i++) begin
      wstrb_in[i] = we_in & (lsu_bweb[8*i +: 8] != 8'hFF);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    resp    = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      StIdle: begin
        if (acc) begin
          capture = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A response in the timeout cycle still completes normally.
        if (mem_rvalid) begin
          resp    = 1'b1;
          state_d = StDone;
        end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
          tmo     = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= we_in;
        wstrb_q <= wstrb_in;
        addr_q  <= {lsu_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= lsu_wdata;
        off_q   <= lsu_addr[1:0];
      end
      if (resp) begin
        err_q <= mem_rerr;
        if (!we_q) begin
          load_data_q <= mem_rdata >> {off_q, 3'b000};
        end
      end else if (tmo) begin
        err_q       <= 1'b1;
        load_data_q <= '0;
      end
    end
  end

  assign mem_valid  = (state_q == StReq);
  assign mem_we     = we_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign load_data  = load_data_q;
  assign access_err = (state_q == StDone) & err_q;
  assign stall      = ((state_q == StIdle) & acc) | (state_q == StReq) | (state_q == StWait);

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access controller in the MEM stage, directly downstream of the load/store unit.
- Converts the load/store unit's SRAM-style outputs (active-low write enable, active-low bit-write mask, address, pre-shifted store data) into a valid/ready request to the data memory/bus.
- Stalls the pipeline until the response arrives.
- Returns the load word right-aligned by byte offset, so the load/store unit's byte/half extraction from bits [7:0]/[15:0] is correct.

Parameters:
- ADDR_W, 32, address width of lsu_addr and mem_addr.
- TIMEOUT, 255, cycles to wait for mem_rvalid before aborting with error; range 1..65535; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- lsu_read  input  1  load access requested this cycle
- lsu_web  input  1  active-low write enable (0 = store)
- lsu_bweb  input  32  active-low bit write mask (0 = write that bit)
- lsu_addr  input  ADDR_W  byte address
- lsu_wdata  input  32  store data, already lane-positioned
- mem_valid  output  1  request valid
- mem_ready  input  1  memory accepts request
- mem_we  output  1  1 = write request
- mem_wstrb  output  4  byte strobes, 0 for reads
- mem_addr  output  ADDR_W  word-aligned address (lsu_addr with [1:0] = 0)
- mem_wdata  output  32  store data
- mem_rvalid  input  1  response valid (read data or write ack)
- mem_rdata  input  32  read word
- mem_rerr  input  1  response error, qualified by mem_rvalid
- load_data  output  32  aligned load word to the load/store unit
- stall  output  1  hold the pipeline
- access_err  output  1  one-cycle error pulse

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk. Reset values:
  - state = IDLE
  - mem_valid, mem_we, mem_wstrb, mem_addr, mem_wdata = 0
  - load_data = 0, access_err = 0
  - timeout counter = 0
- Access detect: acc = lsu_read | ~lsu_web. If both lsu_read and ~lsu_web are asserted, treat the access as a store.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE:
  - If acc: capture the request, go to REQ.
  - Captured fields: we = ~lsu_web; addr = {lsu_addr[ADDR_W-1:2], 2'b00}; off = lsu_addr[1:0]; wdata = lsu_wdata; wstrb[i] = we & (lsu_bweb[8i+7:8i] != 8'hFF).
- REQ:
  - mem_valid = 1, with payload from registers; payload stays stable while mem_valid is high.
  - On mem_valid & mem_ready, go to WAIT and clear the counter.
  - mem_valid is never dropped before acceptance.
- WAIT:
  - mem_valid = 0; counter increments each cycle.
  - On mem_rvalid: go to DONE. Latch load_data = mem_rdata >> (8*off) (zero-fill), for reads only; stores leave load_data unchanged. Latch err = mem_rerr.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: go to DONE with err = 1, load_data = 0.
  - mem_rvalid in the same cycle as the timeout wins (normal completion).
- DONE:
  - Lasts one cycle; go to IDLE unconditionally.
  - Inputs are ignored in DONE because the pipeline still presents the completing instruction.
  - access_err = err during DONE only.
- stall (combinational) = (IDLE & acc) | REQ | WAIT. stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum access latency: stall high for 2 cycles (IDLE, REQ with ready) plus the response wait.
- mem_rvalid outside WAIT is ignored. mem_ready outside REQ is ignored.
- Reset mid-access (any state): return to IDLE next edge, mem_valid = 0 immediately after, no access_err. An outstanding response arriving later is dropped.
- load_data holds its value between accesses until the next completed read.

Test Plan:
- Load byte: lsu_read=1, lsu_addr=0x1003, mem_ready=1 in REQ, mem_rvalid one cycle later with rdata 0xAABBCCDD -> mem_addr=0x1000, mem_wstrb=0000, load_data=0x000000AA, stall high 3 cycles, access_err=0.
- Store half: lsu_web=0, lsu_addr=0x2002, lsu_bweb=0x0000FFFF, lsu_wdata=0x12340000 -> mem_we=1, mem_wstrb=1100, mem_addr=0x2000, mem_wdata=0x12340000; ack completes and load_data is unchanged.
- Backpressure: mem_ready low for 3 cycles in REQ -> mem_valid held high and mem_addr/mem_wdata stable all 4 cycles; stall high throughout.
- Timeout: TIMEOUT=4, no mem_rvalid -> DONE 4 cycles after acceptance, access_err pulses 1 cycle, load_data=0, then IDLE.
- Error response: mem_rvalid=1 with mem_rerr=1 -> access_err=1 for exactly one cycle in DONE.
- Reset mid-WAIT, then a late mem_rvalid -> state IDLE, mem_valid=0, stall=0 with acc=0, late response ignored. Follow with two back-to-back loads (0x0, 0x4) -> both complete, with no re-issue during DONE.
